// File: rtl/imm_extend_pipe.sv
// Pipelined immediate generator: extends an IN_W-bit field to OUT_W bits by mode,
// registered behind a valid/ready handshake with a single skid entry.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHAMT = 2,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       occ
);

  typedef enum logic [1:0] {
    MODE_SEXT   = 2'd0,
    MODE_ZEXT   = 2'd1,
    MODE_BRANCH = 2'd2,
    MODE_UPPER  = 2'd3
  } mode_e;

  logic                    skid_valid;
  logic [OUT_W-1:0]        skid_data;
  logic [TAG_W-1:0]        skid_tag;
  logic signed [IN_W-1:0]  simm;
  logic [OUT_W-1:0]        sext;
  logic [OUT_W-1:0]        ext;
  logic                    accept;
  logic                    drain;

  assign simm = in_imm;
  // Size cast of a signed operand replicates the sign bit into the upper bits.
  assign sext = OUT_W'(simm);

  always_comb begin
    ext = '0;
    case (mode_e'(in_mode))
      MODE_SEXT:   ext = sext;
      MODE_ZEXT:   ext = OUT_W'(in_imm);
      MODE_BRANCH: ext = sext << SHAMT;
      MODE_UPPER:  ext = OUT_W'(in_imm) << (OUT_W - IN_W);
      default:     ext = '0;
    endcase
  end

  assign in_ready = !skid_valid && !rst;
  assign occ      = {1'b0, out_valid} + {1'b0, skid_valid};
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_tag    <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_tag   <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid && (drain || !out_valid)) begin
      out_valid  <= 1'b1;
      out_data   <= skid_data;
      out_tag    <= skid_tag;
      skid_valid <= 1'b0;
    end else if (accept && (drain || !out_valid)) begin
      out_valid <= 1'b1;
      out_data  <= ext;
      out_tag   <= in_tag;
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= ext;
      skid_tag   <= in_tag;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: vector table plus stall, flush, streaming and
// asynchronous-reset sequences, with a scoreboard checking every output beat.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_imm = '0;
  logic [1:0]  in_mode = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic [1:0]  occ;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned popped = 0;
  logic [36:0] q[$];

  typedef struct {
    logic [15:0] imm;
    logic [1:0]  mode;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[10];

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .SHAMT(2), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
    .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .occ(occ)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output beats are checked in the cycle they are consumed.
  always @(negedge clk) begin
    logic [36:0] e;
    if (!rst && !flush && out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_spurious: got data %0h with empty scoreboard at %0t", out_data, $time);
      end else begin
        e = q.pop_front();
        check("sb_data", 64'(out_data), 64'(e[31:0]));
        check("sb_tag", 64'(out_tag), 64'(e[36:32]));
        popped++;
      end
    end
  end

  // Present one input, push its expectation on the accepting edge; returns at edge+1.
  task automatic send(input logic [15:0] imm, input logic [1:0] mode,
                      input logic [4:0] tag, input logic [31:0] exp);
    bit accepted = 0;
    in_valid = 1'b1;
    in_imm   = imm;
    in_mode  = mode;
    in_tag   = tag;
    for (int n = 0; n < 50 && !accepted; n++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back({tag, exp});
        accepted = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!accepted) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no accept expected accept for imm %0h", imm);
    end
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    vt[0] = '{16'h8001, 2'd0, 5'd3,  32'hFFFF8001};
    vt[1] = '{16'h8001, 2'd1, 5'd7,  32'h00008001};
    vt[2] = '{16'hFFFF, 2'd2, 5'd1,  32'hFFFFFFFC};
    vt[3] = '{16'h7FFF, 2'd2, 5'd2,  32'h0001FFFC};
    vt[4] = '{16'h1234, 2'd3, 5'd4,  32'h12340000};
    vt[5] = '{16'h7FFF, 2'd0, 5'd5,  32'h00007FFF};
    vt[6] = '{16'hFFFF, 2'd1, 5'd31, 32'h0000FFFF};
    vt[7] = '{16'h8000, 2'd2, 5'd9,  32'hFFFE0000};
    vt[8] = '{16'h8000, 2'd3, 5'd10, 32'h80000000};
    vt[9] = '{16'h0000, 2'd0, 5'd0,  32'h00000000};

    // Reset state
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_occ", 64'(occ), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    #10 rst = 1'b0;
    #1;
    check("rst_release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Vector table, one cycle latency each
    for (int i = 0; i < 10; i++) begin
      send(vt[i].imm, vt[i].mode, vt[i].tag, vt[i].exp);
      check("lat_valid", 64'(out_valid), 64'd1);
      check("lat_data", 64'(out_data), 64'(vt[i].exp));
      check("lat_tag", 64'(out_tag), 64'(vt[i].tag));
    end
    idle(2);
    check("table_drained", 64'(occ), 64'd0);

    // Backpressure: A, B fill the stage, C waits upstream
    out_ready = 1'b0;
    send(16'h0001, 2'd1, 5'd11, 32'h00000001);
    send(16'h0002, 2'd1, 5'd12, 32'h00000002);
    check("bp_occ2", 64'(occ), 64'd2);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    in_imm   = 16'h0003;
    in_mode  = 2'd1;
    in_tag   = 5'd13;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("bp_stall_data", 64'(out_data), 64'h1);
      check("bp_stall_tag", 64'(out_tag), 64'd11);
      check("bp_stall_occ", 64'(occ), 64'd2);
    end
    out_ready = 1'b1;
    begin
      int unsigned p0;
      p0 = popped;
      send(16'h0003, 2'd1, 5'd13, 32'h00000003);
      // A and B consumed on the two edges that brought C in
      check("bp_consecutive", 64'(popped - p0), 64'd2);
      check("bp_c_data", 64'(out_data), 64'h3);
    end
    idle(1);
    check("bp_occ0", 64'(occ), 64'd0);

    // Flush with both entries held and a same-cycle input
    out_ready = 1'b0;
    send(16'h00AA, 2'd1, 5'd20, 32'h000000AA);
    send(16'h00BB, 2'd1, 5'd21, 32'h000000BB);
    check("fl_occ2", 64'(occ), 64'd2);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_imm   = 16'h00CC;
    in_tag   = 5'd22;
    q.delete();
    idle(1);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_occ", 64'(occ), 64'd0);
    check("fl_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("fl_no_ghost", 64'(out_valid), 64'd0);
    end

    // Streaming: accept and drain every cycle, skid unused
    begin
      int unsigned p0;
      p0 = popped;
      for (int i = 0; i < 8; i++) begin
        logic [15:0] v;
        v = 16'(i * 16'h1111 + 16'h8000);
        send(v, 2'd1, 5'(i), {16'h0000, v});
        check("st_occ_le1", 64'(occ <= 2'd1), 64'd1);
      end
      idle(2);
      check("st_count", 64'(popped - p0), 64'd8);
    end

    // Asynchronous reset with both entries full
    out_ready = 1'b0;
    send(16'h0055, 2'd0, 5'd1, 32'h00000055);
    send(16'h0066, 2'd0, 5'd2, 32'h00000066);
    check("ar_occ2", 64'(occ), 64'd2);
    #1 rst = 1'b1;
    #1;
    check("ar_out_valid", 64'(out_valid), 64'd0);
    check("ar_occ", 64'(occ), 64'd0);
    check("ar_out_data", 64'(out_data), 64'd0);
    check("ar_in_ready", 64'(in_ready), 64'd0);
    q.delete();
    idle(1);
    check("ar_in_ready_held", 64'(in_ready), 64'd0);
    #2 rst = 1'b0;
    #1;
    check("ar_release", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    send(16'hFFFE, 2'd0, 5'd17, 32'hFFFFFFFE);
    idle(3);
    check("sb_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
